// File: rtl/clock_pkg.sv
// Shared constants, output-format enum and hour conversion for the RTC core.
package clock_pkg;

  localparam int SEC_MAX    = 59;
  localparam int MIN_MAX    = 59;
  localparam int HOUR24_MAX = 23;
  localparam int HOUR12_MAX = 12;

  typedef enum logic {
    FMT_BIN,
    FMT_BCD
  } clk_fmt_e;

  // Map a 24-hour value (0..23) onto the 12-hour dial (1..12); midnight reads 12.
  function automatic logic [7:0] to_hour12(input logic [7:0] h24);
    logic [7:0] h12;
    if (h24 == 8'd0) begin
      h12 = 8'(HOUR12_MAX);
    end else if (h24 > 8'(HOUR12_MAX)) begin
      h12 = h24 - 8'(HOUR12_MAX);
    end else begin
      h12 = h24;
    end
    return h12;
  endfunction

endpackage

// File: rtl/clock_bin2bcd.sv
// Combinational 0..99 binary to packed two-digit BCD (tens in [7:4], units in [3:0]).
module clock_bin2bcd
  import clock_pkg::*;
(
  input  logic [7:0] bin,
  output logic [7:0] bcd
);

  // Split the value into decimal digits; inputs above 99 are outside the intended range.
  always_comb begin
    bcd = {4'(bin / 8'd10), 4'(bin % 8'd10)};
  end

endmodule

// File: rtl/clock_rtc.sv
// Real-time clock core: prescaled seconds counter, 24-hour binary state,
// 12/24-hour display, optional BCD output, validated load and minute alarm.
module clock_rtc
  import clock_pkg::*;
#(
  parameter int unsigned TICK_DIV = 1,
  parameter int unsigned BCD      = 0,
  parameter int unsigned RESET_HH = 6
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       ena,
  input  logic       mode24,
  input  logic       load_en,
  input  logic [7:0] load_hh,
  input  logic [7:0] load_mm,
  input  logic [7:0] load_ss,
  input  logic       alarm_en,
  input  logic [7:0] alarm_hh,
  input  logic [7:0] alarm_mm,
  output logic [7:0] hh,
  output logic [7:0] mm,
  output logic [7:0] ss,
  output logic       pm,
  output logic       sec_tick,
  output logic       alarm,
  output logic       load_err
);

  localparam int unsigned PRE_W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [PRE_W-1:0] PRE_LAST = PRE_W'(TICK_DIV - 1);
  localparam clk_fmt_e OUT_FMT = (BCD != 0) ? FMT_BCD : FMT_BIN;

  logic [PRE_W-1:0] pre_q;
  logic [4:0]       h_q;
  logic [5:0]       m_q;
  logic [5:0]       s_q;

  logic [4:0] h_nxt;
  logic [5:0] m_nxt;
  logic [5:0] s_nxt;

  logic tick;
  logic load_ok;
  logic load_bad;
  logic alarm_valid;
  logic alarm_hit;

  logic [7:0] hh_bin;
  logic [7:0] mm_bin;
  logic [7:0] ss_bin;

  assign tick     = ena && (pre_q == PRE_LAST);
  assign load_ok  = load_en
                 && (load_hh <= 8'(HOUR24_MAX))
                 && (load_mm <= 8'(MIN_MAX))
                 && (load_ss <= 8'(SEC_MAX));
  assign load_bad = load_en && !load_ok;

  // Time one second ahead of the current state, with minute/hour/day rollover.
  always_comb begin
    s_nxt = s_q;
    m_nxt = m_q;
    h_nxt = h_q;
    if (s_q == 6'(SEC_MAX)) begin
      s_nxt = '0;
      if (m_q == 6'(MIN_MAX)) begin
        m_nxt = '0;
        if (h_q == 5'(HOUR24_MAX)) begin
          h_nxt = '0;
        end else begin
          h_nxt = h_q + 5'd1;
        end
      end else begin
        m_nxt = m_q + 6'd1;
      end
    end else begin
      s_nxt = s_q + 6'd1;
    end
  end

  // The alarm matches only the exact HH:MM:00 instant reached by a tick; bad alarm values never match.
  assign alarm_valid = (alarm_hh <= 8'(HOUR24_MAX)) && (alarm_mm <= 8'(MIN_MAX));
  assign alarm_hit   = alarm_en && alarm_valid
                    && (alarm_hh == {3'b000, h_nxt})
                    && (alarm_mm == {2'b00, m_nxt})
                    && (s_nxt == 6'd0);

  // Prescaler, time state and event strobes; a valid load overrides any tick in the same cycle.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      pre_q    <= '0;
      h_q      <= 5'(RESET_HH);
      m_q      <= '0;
      s_q      <= '0;
      sec_tick <= 1'b0;
      alarm    <= 1'b0;
      load_err <= 1'b0;
    end else begin
      sec_tick <= 1'b0;
      alarm    <= 1'b0;
      load_err <= load_bad;
      if (load_ok) begin
        h_q   <= load_hh[4:0];
        m_q   <= load_mm[5:0];
        s_q   <= load_ss[5:0];
        pre_q <= '0;
      end else begin
        if (ena) begin
          pre_q <= tick ? '0 : pre_q + PRE_W'(1);
        end
        if (tick) begin
          h_q      <= h_nxt;
          m_q      <= m_nxt;
          s_q      <= s_nxt;
          sec_tick <= 1'b1;
          alarm    <= alarm_hit;
        end
      end
    end
  end

  assign hh_bin = mode24 ? 8'(h_q) : to_hour12(8'(h_q));
  assign mm_bin = 8'(m_q);
  assign ss_bin = 8'(s_q);
  assign pm     = (h_q >= 5'(HOUR12_MAX));

  generate
    if (OUT_FMT == FMT_BCD) begin : g_bcd
      clock_bin2bcd u_hh (.bin(hh_bin), .bcd(hh));
      clock_bin2bcd u_mm (.bin(mm_bin), .bcd(mm));
      clock_bin2bcd u_ss (.bin(ss_bin), .bcd(ss));
    end else begin : g_bin
      assign hh = hh_bin;
      assign mm = mm_bin;
      assign ss = ss_bin;
    end
  endgenerate

endmodule

// File: doc/clock_rtc.md
# clock_rtc

Parametrised real-time clock core replacing the fixed 12-hour counter. It has an internal prescaler, so it counts seconds from a fast system clock, and it supports 12/24-hour display modes selectable at run time. It can output binary or packed BCD, accepts a validated time load, and has a minute-resolution alarm. It drives the display/formatting logic and raises one-cycle event strobes for software-visible status.

## Interface
Parameters:
- TICK_DIV, 1: `clk` cycles per second; 1 means one second per enabled cycle. Legal range 1..2^32-1.
- BCD, 0: 0 gives binary outputs; 1 gives packed BCD outputs (tens in [7:4], units in [3:0]).
- RESET_HH, 6: reset hour, 24-hour binary, 0..23.

Ports:
- clk  in  1  system clock; all state changes on its rising edge.
- reset_n  in  1  asynchronous, active-low reset.
- ena  in  1  count enable; gates the prescaler.
- mode24  in  1  1 = 24-hour display; 0 = 12-hour display.
- load_en  in  1  single-cycle time-load request.
- load_hh / load_mm / load_ss  in  8 each  load value; 24-hour binary, regardless of BCD/mode24.
- alarm_en  in  1  alarm enable.
- alarm_hh / alarm_mm  in  8 each  alarm time; 24-hour binary.
- hh / mm / ss  out  8 each  current time in the selected format.
- pm  out  1  1 when the internal hour is 12..23, in both modes.
- sec_tick  out  1  one-cycle strobe on each second advance.
- alarm  out  1  one-cycle strobe on alarm match.
- load_err  out  1  one-cycle strobe on a rejected load.

## Operation
- Internal state is binary 24-hour: h 0..23, m 0..59, s 0..59. It is independent of mode24 and BCD.
- Prescaler counter: width clog2(TICK_DIV), minimum 1 bit.
  - When ena=1: if the counter equals TICK_DIV-1, it returns to 0 and a tick occurs; otherwise it increments.
  - When ena=0: the counter holds.
- On a tick:
  - s increments.
  - On s=59: s becomes 0 and m increments.
  - On m=59 as well: m becomes 0 and h increments.
  - On h=23 as well: h becomes 0. So 23:59:59 becomes 00:00:00.
- Display hour:
  - mode24=1: display hour is h.
  - mode24=0: h=0 displays 12; h=1..12 displays h; h=13..23 displays h-12.
  - In 12-hour mode, 11:59:59 AM becomes 12:00:00 with pm=1, and 12:59:59 PM becomes 01:00:00 with pm still 1.
- Output formatting is combinational from state. Toggling mode24 or changing BCD selection changes hh in the same cycle with no state change.
- Load:
  - On load_en=1, if load_hh≤23, load_mm≤59 and load_ss≤59: state takes the load values, the prescaler clears to 0, and any tick in that cycle is discarded (load wins).
  - If any field is out of range: state is unchanged, load_err=1 next cycle, and the prescaler continues normally.
  - Load is accepted even when ena=0.
- Alarm:
  - alarm asserts for one cycle when a tick moves the state to alarm_hh:alarm_mm:00 while alarm_en=1.
  - A load to exactly that time does not fire the alarm.
  - Out-of-range alarm values never match.
- Reset (reset_n=0, asynchronous): h=RESET_HH, m=0, s=0, prescaler=0, and sec_tick/alarm/load_err=0.
  - Outputs at default parameters: hh=6, mm=0, ss=0, pm=0.
  - Reset mid-count discards any partial second.

## Timing
- Tick edge: the edge on which the prescaler is at TICK_DIV-1 and ena=1. After that edge, the new time, sec_tick=1 and (if matched) alarm=1 are all visible in the same cycle.
- Seconds period with ena held high is exactly TICK_DIV cycles.
- Load: on the edge sampling load_en=1, the new time appears after that edge. The first tick then follows TICK_DIV edges later.
- load_err is registered: high for exactly the one cycle after the rejecting edge.
- Strobes never stretch. Back-to-back events, e.g. with TICK_DIV=1, give one pulse per event.
- Deasserting reset_n is synchronous-safe: counting resumes on the first edge with reset_n=1.

## Structure
- Package clock_pkg holds:
  - constants SEC_MAX=59, MIN_MAX=59, HOUR24_MAX=23, HOUR12_MAX=12;
  - a `clk_fmt_e` enum {FMT_BIN, FMT_BCD};
  - function to_hour12 (0..23 → 1..12).
- One sub-module, clock_bin2bcd: combinational 8-bit binary (0..99) to packed BCD. Instantiate it three times under `if (BCD)` generate; with BCD=0 the outputs pass through unconverted.
- Prescaler, time counter, load/alarm compare and strobe registers stay in clock_rtc.

## Test plan
- Reset with defaults → hh=6, mm=0, ss=0, pm=0, all strobes 0. Assert reset_n=0 mid-second → same values immediately, without waiting for a clock edge.
- TICK_DIV=4, ena=1 for 8 cycles → ss=2 and exactly 2 sec_tick pulses, 4 cycles apart. Hold ena=0 for 10 cycles → no change.
- mode24=0: load 11:59:59 and tick → hh=12, pm=1. Load 12:59:59 and tick → hh=1, pm=1. Load 23:59:59 and tick → hh=12, mm=0, ss=0, pm=0.
- BCD=1, mode24=1: load 19:45:38 → hh=8'h19, mm=8'h45, ss=8'h38. Switch mode24=0 → hh=8'h07 in the same cycle.
- Load 24:00:00 → state unchanged, load_err=1 for one cycle. Load 10:20:30 in the same cycle as a tick → state reads 10:20:30.
- alarm_en=1 with alarm 07:00: load 06:59:58, two ticks → alarm=1 only on the second. Load 07:00:00 directly → alarm stays 0.
